// File: rtl/motor_uart_pkg.sv
// Shared types and constants for the motor-command
// serial receiver.
package motor_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam logic [7:0] ALL_STOP = 8'd0;
  localparam logic [7:0] M1_ZERO  = 8'd64;
  localparam logic [7:0] M2_ZERO  = 8'd192;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchroniser, oversampling tick,
// framing FSM and shift register.
module uart_rx_core
  import motor_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [SW-1:0] S_MAX   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_MID   = SW'(OVERSAMPLE / 2);

  logic            sync1, sync2, sync3;
  logic [DW-1:0]   div_cnt;
  logic [SW-1:0]   samp_cnt;
  logic [SW-1:0]   samp_nxt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  rx_state_t       state;
  logic            fall;
  logic            tick;
  logic            mid;

  assign fall     = sync3 & ~sync2;
  assign tick     = (div_cnt == DIV_MAX);
  assign samp_nxt = (samp_cnt == S_MAX) ? '0
                                        : samp_cnt + 1'b1;
  assign mid      = tick && (samp_nxt == S_MID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      sync3      <= 1'b1;
      div_cnt    <= '0;
      samp_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      state      <= IDLE;
    end else begin
      sync1      <= rx;
      sync2      <= sync1;
      sync3      <= sync2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      if (tick)
        samp_cnt <= samp_nxt;
      unique case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            div_cnt  <= '0;
            samp_cnt <= '0;
          end
        end
        START: begin
          if (mid) begin
            if (!sync2) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (mid) begin
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= STOP;
          end
        end
        STOP: begin
          if (mid) begin
            if (sync2) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              samp_cnt  <= '0;
              state     <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          // samp_cnt counts consecutive high ticks here
          if (tick) begin
            if (!sync2) begin
              samp_cnt <= '0;
            end else if (samp_cnt == S_MAX) begin
              samp_cnt <= '0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/motor_uart_rx.sv
// Motor-link receive end: UART core, speed decode
// and link watchdog.
module motor_uart_rx
  import motor_uart_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 9600,
  parameter int OVERSAMPLE     = 16,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              uart_in,
  output logic [7:0]        rx_byte,
  output logic              byte_valid,
  output logic              frame_err,
  output logic signed [7:0] m1_speed,
  output logic signed [7:0] m2_speed,
  output logic              cmd_valid,
  output logic              link_timeout
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_PRE = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_ONE = WW'(1);

  logic [WW-1:0] wd_cnt;

  uart_rx_core #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_core (
    .clk        (CLOCK_50),
    .rst_n      (reset_n),
    .rx         (uart_in),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      m1_speed     <= '0;
      m2_speed     <= '0;
      cmd_valid    <= 1'b0;
      link_timeout <= 1'b1;
      wd_cnt       <= '0;
    end else begin
      cmd_valid <= 1'b0;
      if (byte_valid) begin
        // byte cycle is count 0, so the next one is 1
        wd_cnt       <= WD_ONE;
        link_timeout <= 1'b0;
        cmd_valid    <= 1'b1;
        if (rx_byte == ALL_STOP) begin
          m1_speed <= '0;
          m2_speed <= '0;
        end else if (!rx_byte[7]) begin
          m1_speed <= $signed(rx_byte - M1_ZERO);
        end else begin
          m2_speed <= $signed(rx_byte - M2_ZERO);
        end
      end else if (wd_cnt >= WD_PRE) begin
        wd_cnt       <= WD_MAX;
        link_timeout <= 1'b1;
        m1_speed     <= '0;
        m2_speed     <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_motor_uart_rx.sv
// Directed bench for motor_uart_rx at a scaled clock
// (4 clocks per sample tick, 64 per bit).
module tb_motor_uart_rx;

  localparam int TO = 2000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              uart_in = 1'b1;
  logic [7:0]        rx_byte;
  logic              byte_valid;
  logic              frame_err;
  logic signed [7:0] m1_speed;
  logic signed [7:0] m2_speed;
  logic              cmd_valid;
  logic              link_timeout;

  int checks = 0;
  int failures = 0;
  int bit_len = 64;
  int cyc = 0;
  int bv_n = 0, fe_n = 0, cv_n = 0, lt_n = 0;
  int bv_cyc = 0, cv_cyc = 0, lt_cyc = 0;
  logic       cv_lt = 1'b1;
  logic       lt_prev = 1'b0;
  logic [7:0] cv_m1 = '0, cv_m2 = '0;

  motor_uart_rx #(
    .CLK_FREQ       (614_400),
    .BAUD           (9600),
    .OVERSAMPLE     (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK_50     (clk),
    .reset_n      (reset_n),
    .uart_in      (uart_in),
    .rx_byte      (rx_byte),
    .byte_valid   (byte_valid),
    .frame_err    (frame_err),
    .m1_speed     (m1_speed),
    .m2_speed     (m2_speed),
    .cmd_valid    (cmd_valid),
    .link_timeout (link_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    lt_prev <= link_timeout;
    if (byte_valid) begin
      bv_n   <= bv_n + 1;
      bv_cyc <= cyc;
    end
    if (frame_err) fe_n <= fe_n + 1;
    if (cmd_valid) begin
      cv_n   <= cv_n + 1;
      cv_cyc <= cyc;
      cv_lt  <= link_timeout;
      cv_m1  <= m1_speed;
      cv_m2  <= m2_speed;
    end
    if (link_timeout && !lt_prev) begin
      lt_n   <= lt_n + 1;
      lt_cyc <= cyc;
    end
  end

  task automatic send_byte(input logic [7:0] d,
                           input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_in = f[i];
      repeat (bit_len - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_in = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (link_timeout !== 1'b1) begin
      failures++;
      $display("FAIL rst_lt_in_reset: got %b want 1",
               link_timeout);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (rx_byte !== 8'h00) begin
      failures++;
      $display("FAIL rst_rx_byte: got %h want 00", rx_byte);
    end
    checks++;
    if (m1_speed !== 8'h00 || m2_speed !== 8'h00) begin
      failures++;
      $display("FAIL rst_speeds: got %h/%h want 00/00",
               m1_speed, m2_speed);
    end
    checks++;
    if (link_timeout !== 1'b1) begin
      failures++;
      $display("FAIL rst_lt: got %b want 1", link_timeout);
    end
    checks++;
    if (bv_n != 0 || fe_n != 0 || cv_n != 0) begin
      failures++;
      $display("FAIL rst_pulses: bv=%0d fe=%0d cv=%0d want 0",
               bv_n, fe_n, cv_n);
    end
  endtask

  task automatic test_byte_7f();
    int b0, c0;
    b0 = bv_n;
    c0 = cv_n;
    bit_len = 65;
    send_byte(8'h7F, 1'b1);
    bit_len = 64;
    repeat (4) @(negedge clk);
    checks++;
    if (bv_n != b0 + 1) begin
      failures++;
      $display("FAIL 7f_bv_count: got %0d want %0d",
               bv_n - b0, 1);
    end
    checks++;
    if (rx_byte !== 8'h7F) begin
      failures++;
      $display("FAIL 7f_rx_byte: got %h want 7f", rx_byte);
    end
    checks++;
    if (cv_n != c0 + 1 || cv_cyc != bv_cyc + 1) begin
      failures++;
      $display("FAIL 7f_cmd_valid: n=%0d lat=%0d want 1/1",
               cv_n - c0, cv_cyc - bv_cyc);
    end
    checks++;
    if (m1_speed !== 8'h3F || m2_speed !== 8'h00) begin
      failures++;
      $display("FAIL 7f_speeds: got %h/%h want 3f/00",
               m1_speed, m2_speed);
    end
    checks++;
    if (cv_lt !== 1'b0 || link_timeout !== 1'b0) begin
      failures++;
      $display("FAIL 7f_lt_fall: got %b/%b want 0/0",
               cv_lt, link_timeout);
    end
  endtask

  task automatic test_m1_m2();
    send_byte(8'h01, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (m1_speed !== 8'hC1 || m2_speed !== 8'h00) begin
      failures++;
      $display("FAIL m_01: got %h/%h want c1/00",
               m1_speed, m2_speed);
    end
    send_byte(8'hC0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (m1_speed !== 8'hC1 || m2_speed !== 8'h00) begin
      failures++;
      $display("FAIL m_c0: got %h/%h want c1/00",
               m1_speed, m2_speed);
    end
    send_byte(8'h80, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (m1_speed !== 8'hC1 || m2_speed !== 8'hC0) begin
      failures++;
      $display("FAIL m_80: got %h/%h want c1/c0",
               m1_speed, m2_speed);
    end
  endtask

  task automatic test_all_stop();
    send_byte(8'h54, 1'b1);
    send_byte(8'hB6, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (m1_speed !== 8'h14 || m2_speed !== 8'hF6) begin
      failures++;
      $display("FAIL stop_pre: got %h/%h want 14/f6",
               m1_speed, m2_speed);
    end
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (cv_m1 !== 8'h00 || cv_m2 !== 8'h00) begin
      failures++;
      $display("FAIL stop_zero: got %h/%h want 00/00",
               cv_m1, cv_m2);
    end
    checks++;
    if (cv_cyc != bv_cyc + 1) begin
      failures++;
      $display("FAIL stop_latency: got %0d want 1",
               cv_cyc - bv_cyc);
    end
  endtask

  task automatic test_frame_err();
    int b0, f0;
    b0 = bv_n;
    f0 = fe_n;
    send_byte(8'hA5, 1'b0);
    repeat (2 * bit_len) @(negedge clk);
    checks++;
    if (fe_n != f0 + 1 || bv_n != b0) begin
      failures++;
      $display("FAIL fe_bad: fe=%0d bv=%0d want 1/0",
               fe_n - f0, bv_n - b0);
    end
    checks++;
    if (rx_byte !== 8'h00) begin
      failures++;
      $display("FAIL fe_hold: got %h want 00", rx_byte);
    end
    send_byte(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (bv_n != b0 + 1 || rx_byte !== 8'h55) begin
      failures++;
      $display("FAIL fe_next: bv=%0d rx=%h want 1/55",
               bv_n - b0, rx_byte);
    end
    checks++;
    if (fe_n != f0 + 1 || m1_speed !== 8'h15) begin
      failures++;
      $display("FAIL fe_next_m1: fe=%0d m1=%h want 1/15",
               fe_n - f0, m1_speed);
    end
  endtask

  task automatic test_glitch();
    int b0, f0;
    b0 = bv_n;
    f0 = fe_n;
    @(negedge clk);
    uart_in = 1'b0;
    repeat (10) @(negedge clk);
    uart_in = 1'b1;
    repeat (2 * bit_len) @(negedge clk);
    checks++;
    if (bv_n != b0 || fe_n != f0) begin
      failures++;
      $display("FAIL glitch: bv=%0d fe=%0d want 0/0",
               bv_n - b0, fe_n - f0);
    end
    send_byte(8'h41, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (bv_n != b0 + 1 || m1_speed !== 8'h01) begin
      failures++;
      $display("FAIL glitch_after: bv=%0d m1=%h want 1/01",
               bv_n - b0, m1_speed);
    end
  endtask

  task automatic test_reset_mid();
    int b0, f0;
    logic [7:0] d;
    d = 8'h3C;
    b0 = bv_n;
    f0 = fe_n;
    @(negedge clk);
    uart_in = 1'b0;
    repeat (bit_len) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_in = d[i];
      repeat (bit_len) @(negedge clk);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rx_byte !== 8'h00 || m1_speed !== 8'h00) begin
      failures++;
      $display("FAIL rmid_async: rx=%h m1=%h want 00/00",
               rx_byte, m1_speed);
    end
    checks++;
    if (link_timeout !== 1'b1 || cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_flags: lt=%b cv=%b want 1/0",
               link_timeout, cmd_valid);
    end
    uart_in = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (20 * bit_len) @(negedge clk);
    checks++;
    if (bv_n != b0 || fe_n != f0) begin
      failures++;
      $display("FAIL rmid_discard: bv=%0d fe=%0d want 0/0",
               bv_n - b0, fe_n - f0);
    end
  endtask

  task automatic test_timeout();
    int b, n0, c0;
    send_byte(8'h50, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (m1_speed !== 8'h10 || link_timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_pre: m1=%h lt=%b want 10/0",
               m1_speed, link_timeout);
    end
    b = bv_cyc;
    n0 = lt_n;
    c0 = cv_n;
    for (int i = 0; i < 3 * TO && lt_n == n0; i++)
      @(negedge clk);
    checks++;
    if (lt_n != n0 + 1) begin
      failures++;
      $display("FAIL to_rise: got %0d rises want 1",
               lt_n - n0);
    end
    checks++;
    if (lt_cyc - b != TO) begin
      failures++;
      $display("FAIL to_delay: got %0d want %0d",
               lt_cyc - b, TO);
    end
    @(negedge clk);
    checks++;
    if (m1_speed !== 8'h00 || link_timeout !== 1'b1) begin
      failures++;
      $display("FAIL to_force: m1=%h lt=%b want 00/1",
               m1_speed, link_timeout);
    end
    checks++;
    if (cv_n != c0) begin
      failures++;
      $display("FAIL to_no_cv: got %0d pulses want 0",
               cv_n - c0);
    end
  endtask

  initial begin
    test_reset();
    test_byte_7f();
    test_m1_m2();
    test_all_stop();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/motor_uart_rx.md
Name: motor_uart_rx

Overview:
Receive end of the motor-drive serial link: the counterpart to the motor-command UART transmitter that drives GPIO[5].
- Deserialises 8N1 UART bytes using 16x oversampling.
- Decodes the simplified-serial motor protocol into signed per-motor speed commands.
- Runs a link watchdog.
- Used for loopback self-check of the drive path, and on a second board as a motor-command sink.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
OVERSAMPLE, 16, samples per bit
TIMEOUT_CYCLES, 25_000_000, cycles without a valid byte before the watchdog fires (0.5 s)

Ports:
CLOCK_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
uart_in  in  1  serial line; idles high; asynchronous to CLOCK_50
rx_byte  out  8  last correctly framed byte
byte_valid  out  1  1-cycle pulse when rx_byte updates
frame_err  out  1  1-cycle pulse when the stop bit is sampled low
m1_speed  out  8  signed motor-1 command, range -63..+63
m2_speed  out  8  signed motor-2 command, range -64..+63
cmd_valid  out  1  1-cycle pulse when m1_speed/m2_speed update
link_timeout  out  1  high while the watchdog has expired

Behaviour:
Reset values:
- rx_byte = 0; m1_speed = 0; m2_speed = 0.
- byte_valid, frame_err, cmd_valid = 0.
- link_timeout = 1 (no link yet).
- FSM = IDLE; all counters = 0.

Input and sampling:
- uart_in passes through a 2-flop synchroniser. Falling-edge detection uses the synchronised value.
- Tick divider = CLK_FREQ/(BAUD*OVERSAMPLE), integer division, so 325 at defaults. It emits a 1-cycle sample tick.
- The divider restarts on entry to START so the sample phase aligns to the detected edge.
- Sample counter is 0..OVERSAMPLE-1. Bits are sampled at count OVERSAMPLE/2 (mid-bit).

FSM:
- IDLE: on synchronised falling edge -> START.
- START: at mid-bit, line low -> DATA with bit index 0; line high (glitch) -> IDLE, no outputs.
- DATA: sample at mid-bit, LSB first, shifted into an 8-bit shift register. After bit 7 -> STOP.
- STOP, line high at mid-bit: rx_byte <= shift register; byte_valid pulses the same cycle; -> IDLE.
- STOP, line low at mid-bit: frame_err pulses; rx_byte is unchanged; -> WAIT_IDLE.
- WAIT_IDLE: stay until the synchronised line has been high for one full bit time (OVERSAMPLE ticks) -> IDLE. Any low sample restarts the count.
- Next start-edge detection is enabled immediately in IDLE. Resynchronisation after the stop bit does not wait for the remaining half bit.

Decode (registered, one cycle after byte_valid; cmd_valid pulses with the update):
- Byte 0x00: m1_speed = 0 and m2_speed = 0.
- Byte 0x01..0x7F: m1_speed = byte - 64; m2_speed holds.
- Byte 0x80..0xFF: m2_speed = byte - 192, as signed 8-bit; m1_speed holds.

Watchdog:
- Counter is cleared on every byte_valid and increments otherwise, saturating at TIMEOUT_CYCLES.
- On reaching TIMEOUT_CYCLES: link_timeout = 1 and m1_speed/m2_speed are forced to 0. cmd_valid does not pulse.
- link_timeout clears on the cycle cmd_valid pulses.
- If byte_valid and expiry fall on the same cycle, the byte wins: the counter clears and no timeout occurs.
- frame_err does not clear the watchdog.

Reset mid-frame: asynchronous reset returns every register to its reset value. A partially received byte is discarded and never reported.

Decomposition:
Shared package motor_uart_pkg holds:
- the state enum rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE};
- localparams ALL_STOP = 8'd0, M1_ZERO = 8'd64, M2_ZERO = 8'd192.

One sub-module, uart_rx_core, contains the synchroniser, tick divider, FSM and shift register, and outputs rx_byte/byte_valid/frame_err. motor_uart_rx instantiates it and adds the decode and watchdog logic.

Test Plan:
- Send 0x7F at 9600 baud (5200-cycle bit period, within +/-2% tolerance) -> byte_valid once with rx_byte = 0x7F; next cycle cmd_valid pulses, m1_speed = +63, m2_speed = 0, link_timeout falls.
- Send 0x01 then 0xC0 then 0x80 -> m1_speed = -63; then m2_speed = 0; then m2_speed = -64; m1_speed stays -63 throughout.
- After m1_speed = +20 and m2_speed = -10, send 0x00 -> both read 0 one cycle after byte_valid.
- Send a frame with stop bit low, followed by 0x55 after one idle bit time -> frame_err pulses once and no byte_valid for the bad frame; 0x55 is then received correctly.
- Drive a 2 us low glitch on an idle line -> no byte_valid, no frame_err; FSM returns to IDLE.
- Receive 0x50 (m1_speed = +16), then idle for TIMEOUT_CYCLES -> link_timeout rises and m1_speed = 0 exactly TIMEOUT_CYCLES after byte_valid; also, assert reset_n low mid-byte -> all outputs reach reset values immediately and the partial byte is never reported.
